// File: rtl/reg_file_core_if.sv
// Write-port and register-output bundle of the LC-3 register file.
// master drives the write port and observes the registers; slave is the storage core.
interface reg_file_core_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             ld_reg;
  logic [2:0]       dr;
  logic             ld_cc;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] r0_q;
  logic [WIDTH-1:0] r1_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] r3_q;
  logic [WIDTH-1:0] r4_q;
  logic [WIDTH-1:0] r5_q;
  logic [WIDTH-1:0] r6_q;
  logic [WIDTH-1:0] r7_q;
  logic             n;
  logic             z;
  logic             p;

  modport master (
    output ld_reg, dr, ld_cc, bus,
    input  r0_q, r1_q, r2_q, r3_q, r4_q, r5_q, r6_q, r7_q, n, z, p
  );

  modport slave (
    input  ld_reg, dr, ld_cc, bus,
    output r0_q, r1_q, r2_q, r3_q, r4_q, r5_q, r6_q, r7_q, n, z, p
  );
endinterface

// File: rtl/reg_file_core.sv
// LC-3 register storage: R0-R7 with one write port plus the one-hot N/Z/P register.
// All registers are exposed in parallel; read selection happens downstream.
module reg_file_core #(
  parameter int unsigned WIDTH    = 16,
  parameter logic [2:0]  CC_RESET = 3'b010
) (
  input logic             clk,
  input logic             reset,
  reg_file_core_if.slave  rf
);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [2:0]       cc_q;
  logic [2:0]       cc_d;
  logic [2:0]       cc_bus;
  logic [7:0]       wr_sel;

  // Classification is exhaustive, so cc_bus is always one-hot.
  always_comb begin
    if (rf.bus[WIDTH-1]) begin
      cc_bus = 3'b100;
    end else if (rf.bus == '0) begin
      cc_bus = 3'b010;
    end else begin
      cc_bus = 3'b001;
    end
  end

  // Gate the decode with ld_reg so an undefined dr cannot reach the registers.
  always_comb begin
    wr_sel = 8'h00;
    if (rf.ld_reg) begin
      wr_sel = 8'h01 << rf.dr;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = wr_sel[i] ? rf.bus : regs_q[i];
    end
    cc_d = rf.ld_cc ? cc_bus : cc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
      cc_q <= CC_RESET;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cc_q <= cc_d;
    end
  end

  assign rf.r0_q = regs_q[0];
  assign rf.r1_q = regs_q[1];
  assign rf.r2_q = regs_q[2];
  assign rf.r3_q = regs_q[3];
  assign rf.r4_q = regs_q[4];
  assign rf.r5_q = regs_q[5];
  assign rf.r6_q = regs_q[6];
  assign rf.r7_q = regs_q[7];
  assign rf.n    = cc_q[2];
  assign rf.z    = cc_q[1];
  assign rf.p    = cc_q[0];

endmodule
